// File: rtl/repetition_ctrl_pkg.sv
// Shared types and constants for the repetition matcher: qualifier kinds,
// controller states and the latched configuration record.
package repetition_ctrl_pkg;

    localparam int MAX_REPS = 16;
    localparam int CNT_W    = $clog2(MAX_REPS + 1);
    localparam int GAP_W    = 4;

    typedef enum logic {
        CONSECUTIVE = 1'b0,
        GOTO        = 1'b1
    } rep_kind_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        COUNT = 2'd2
    } rep_state_e;

    typedef struct packed {
        rep_kind_e          kind;
        logic [CNT_W-1:0]   reps;
        logic [GAP_W-1:0]   min_gap;
    } rep_cfg_t;

    function automatic logic reps_legal(input logic [CNT_W-1:0] reps);
        return (reps != '0) && (reps <= CNT_W'(MAX_REPS));
    endfunction

endpackage

// File: rtl/rep_gap_timer.sv
// Saturating down-counter: loads a spacing value, counts down once per cycle
// and flags when the required idle spacing has elapsed.
module rep_gap_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] value;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (value != '0) begin
            value <= value - W'(1);
        end
    end

    assign zero = (value == '0);

endmodule

// File: rtl/repetition_match_ctrl.sv
// Run-time configurable repetition matcher: consecutive-run detection on a,
// or goto-style counting of b after a with minimum-spacing checking.
module repetition_match_ctrl
    import repetition_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic             cfg_kind,
    input  logic [CNT_W-1:0] cfg_reps,
    input  logic [GAP_W-1:0] cfg_min_gap,
    input  logic             a,
    input  logic             b,
    output logic             match,
    output logic             busy,
    output logic [CNT_W-1:0] count,
    output logic             gap_err,
    output logic             cfg_err
);

    rep_state_e       state_q, state_d;
    rep_cfg_t         cfg_q, cfg_d;
    logic [CNT_W-1:0] count_q, count_d, count_inc;
    logic             match_q, match_d;
    logic             gap_err_q, gap_err_d;
    logic             cfg_err_q, cfg_err_d;
    logic             ready_q;
    logic             timer_load, timer_zero;

    rep_gap_timer #(.W(GAP_W)) u_gap_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (cfg_q.min_gap),
        .zero     (timer_zero)
    );

    assign count_inc = count_q + CNT_W'(1);

    // NOTE: every variable driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        cfg_d      = cfg_q;
        count_d    = count_q;
        match_d    = 1'b0;
        gap_err_d  = gap_err_q;
        cfg_err_d  = 1'b0;
        timer_load = 1'b0;

        if (cfg_valid) begin
            // A new configuration aborts whatever is running and drops a/b.
            cfg_d.kind    = rep_kind_e'(cfg_kind);
            cfg_d.reps    = cfg_reps;
            cfg_d.min_gap = cfg_min_gap;
            count_d       = '0;
            gap_err_d     = 1'b0;
            if (reps_legal(cfg_reps)) begin
                state_d = ARMED;
            end else begin
                state_d   = IDLE;
                cfg_err_d = 1'b1;
            end
        end else begin
            case (state_q)
                IDLE: ;
                ARMED: begin
                    if (a) begin
                        if (cfg_q.kind == CONSECUTIVE) begin
                            if (cfg_q.reps == CNT_W'(1)) begin
                                match_d = 1'b1;
                                count_d = '0;
                            end else begin
                                count_d = CNT_W'(1);
                                state_d = COUNT;
                            end
                        end else begin
                            count_d    = '0;
                            timer_load = 1'b1;
                            state_d    = COUNT;
                        end
                    end
                end
                COUNT: begin
                    if (cfg_q.kind == CONSECUTIVE) begin
                        if (!a) begin
                            count_d = '0;
                            state_d = ARMED;
                        end else if (count_inc == cfg_q.reps) begin
                            match_d = 1'b1;
                            count_d = '0;
                            state_d = ARMED;
                        end else begin
                            count_d = count_inc;
                        end
                    end else if (b) begin
                        timer_load = 1'b1;
                        if (!timer_zero) begin
                            gap_err_d = 1'b1;
                        end
                        if (count_inc == cfg_q.reps) begin
                            match_d = 1'b1;
                            count_d = '0;
                            state_d = ARMED;
                        end else begin
                            count_d = count_inc;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cfg_q     <= '0;
            count_q   <= '0;
            match_q   <= 1'b0;
            gap_err_q <= 1'b0;
            cfg_err_q <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cfg_q     <= cfg_d;
            count_q   <= count_d;
            match_q   <= match_d;
            gap_err_q <= gap_err_d;
            cfg_err_q <= cfg_err_d;
            ready_q   <= 1'b1;
        end
    end

    assign cfg_ready = ready_q;
    assign match     = match_q;
    assign busy      = (state_q == COUNT);
    assign count     = count_q;
    assign gap_err   = gap_err_q;
    assign cfg_err   = cfg_err_q;

endmodule
